nco_sched: RTL
==============

NCO_SCHED -- requirements
Module: nco_sched

Interface
REQ-001 Parameter NCH, default 4: number of NCO channels, power of two, 2..16.
REQ-002 Parameter PW, default 32: phase accumulator and frequency word width.
REQ-003 Parameter NBA, default 22: angle bits issued per sample; the 2 MSBs are the quadrant.
REQ-004 Parameter LAT, default 9: cycles from issue to valid result at the shared ROM + cosine interpolator output, LAT >= 1.
REQ-005 c  in  1  clock; all logic on the rising edge.
REQ-006 r  in  1  reset, synchronous, active-high.
REQ-007 en  in  1  run enable; the slot counter advances only while en=1.
REQ-008 sync  in  1  one-cycle pulse requesting that all phases be zeroed at the next frame boundary.
REQ-009 fw_we  in  1  frequency word write strobe.
REQ-010 fw_ch  in  log2(NCH)  channel index for the write.
REQ-011 fw_d  in  PW  frequency word; unsigned phase increment per frame.
REQ-012 a  out  NBA-2  folded quarter-wave angle to the ROM / interpolator.
REQ-013 s  out  1  issued sign; 1 = result is to be negated.
REQ-014 issue  out  1  a/s valid this cycle.
REQ-015 o_valid  out  1  result at the shared datapath output is valid, aligned LAT cycles after issue.
REQ-016 o_ch  out  log2(NCH)  channel tag aligned with o_valid.
REQ-017 o_sin  out  1  tag aligned with o_valid; 0 = cosine, 1 = sine.
REQ-018 frame  out  1  pulse on the issue cycle of slot 0.

Function
REQ-019 The slot counter k shall run 0..2*NCH-1 and wrap to 0; it shall advance by one per cycle while en=1 and hold while en=0.
REQ-020 Slot k shall issue for channel k>>1: cosine when k is even, sine when k is odd; issue shall equal en.
REQ-021 The working angle shall be the top NBA bits of phase[ch] for cosine, and of phase[ch] - 2^(PW-2) mod 2^PW for sine.
REQ-022 Folding: q = working angle bits [NBA-1:NBA-2], x = bits [NBA-3:0]; q=0 gives a=x, s=0; q=1 gives a=~x, s=1; q=2 gives a=x, s=1; q=3 gives a=~x, s=0.
REQ-023 a and s shall be registered outputs, presented one cycle after the slot is selected; issue shall be delayed identically.
REQ-024 phase[ch] shall be updated to phase[ch] + fw[ch] mod 2^PW in the cycle its sine slot issues, so cos and sin of a pair always use the same phase.
REQ-025 A write with fw_we=1 shall update fw[fw_ch] at the next edge; if that channel accumulates in the same cycle, the old word is used and the new word takes effect from the next frame.
REQ-026 sync shall be latched as pending; when slot 0 is next selected with en=1, all phases shall be zeroed before that slot's angle is formed, and pending shall clear.
REQ-027 A sync arriving in the same cycle that slot 0 is selected shall take effect on the following frame, not the current one.
REQ-028 o_valid, o_ch, o_sin shall be issue, ch and k[0] delayed by exactly LAT cycles through a shift register that shifts every cycle regardless of en.
REQ-029 frame shall be 1 exactly when issue=1 for slot 0.

Reset
REQ-030 While r=1: k=0, all phases=0, all fw=0, sync pending=0, a=0, s=0, issue=0, frame=0.
REQ-031 While r=1, the entire tag delay line shall clear, so that o_valid=0 for LAT cycles after release; results in flight at reset are discarded.
REQ-032 An fw_we coincident with r=1 shall be ignored.

Configuration
REQ-033 Macro NCO_SCHED_DITHER_EN: when defined, a 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) shall be added to the working angle below the NBA-bit cut before truncation, with the LFSR advancing once per issue. When undefined, the angle is plain truncation and no LFSR is present.

Verification
REQ-034 NCH=4, fw[0]=2^30, others 0, en=1 -> channel 0 issues the phase sequence 0, 2^30, 2^31, 3*2^30; the cos (a,s) pairs are (0,0), (all-ones,1), (0,1), (all-ones,0).
REQ-035 fw[1]=0 at phase 0 -> sine slot gives q=3, a=~0, s=0; tagged o_ch=1, o_sin=1 exactly LAT cycles after issue.
REQ-036 fw_we to ch 2 on its sine-slot cycle with fw_d=5, old word 3 -> this frame adds 3; the next frame adds 5.
REQ-037 sync pulse mid-frame with fw[0]=100 -> the next slot 0 issues a=0, s=0, and all channels restart from phase 0 simultaneously.
REQ-038 en toggled 1,0,0,1 -> k holds across the gap; no issue and no o_valid in the corresponding cycles; phase is unchanged.
REQ-039 r asserted with 3 results in flight -> o_valid stays 0 for LAT cycles after release; the first issue after release is slot 0, phase 0.

Source files
------------

// File: rtl/nco_sched_if.sv
// Bus bundle for nco_sched: run/sync controls, frequency-word writes,
// issued quarter-wave angle and the LAT-delayed result tags.
interface nco_sched_if #(
    parameter int NCH = 4,
    parameter int PW  = 32,
    parameter int NBA = 22
);
    localparam int CW = $clog2(NCH);

    logic           en;
    logic           sync;
    logic           fw_we;
    logic [CW-1:0]  fw_ch;
    logic [PW-1:0]  fw_d;
    logic [NBA-3:0] a;
    logic           s;
    logic           issue;
    logic           o_valid;
    logic [CW-1:0]  o_ch;
    logic           o_sin;
    logic           frame;

    modport master (
        output en, sync, fw_we, fw_ch, fw_d,
        input  a, s, issue, o_valid, o_ch, o_sin, frame
    );

    modport slave (
        input  en, sync, fw_we, fw_ch, fw_d,
        output a, s, issue, o_valid, o_ch, o_sin, frame
    );
endinterface

// File: rtl/nco_sched.sv
// Time-multiplexed NCO scheduler: 2*NCH slots (cos/sin per channel) share one
// quarter-wave ROM + interpolator. Optional angle dither: NCO_SCHED_DITHER_EN.
module nco_sched #(
    parameter int NCH = 4,
    parameter int PW  = 32,
    parameter int NBA = 22,
    parameter int LAT = 9
) (
    input logic        c,
    input logic        r,
    nco_sched_if.slave bus
);
    localparam int CW = $clog2(NCH);
    localparam int KW = CW + 1;

    logic [KW-1:0]  k;
    logic [PW-1:0]  phase [NCH];
    logic [PW-1:0]  fw    [NCH];
    logic           pend;
    logic [NBA-3:0] a_r;
    logic           s_r;
    logic           issue_r;
    logic           frame_r;
    logic [CW-1:0]  iss_ch;
    logic           iss_sin;
    logic [CW+1:0]  tag_line [LAT];

    logic [CW-1:0]  ch;
    logic           zero_now;
    logic [PW-1:0]  ph_sel;
    logic [NBA-1:0] ang;
    logic [NBA-3:0] a_n;
    logic           s_n;

    assign ch       = k[KW-1:1];
    // Pending sync only (not the live pulse) so a coincident sync waits a frame.
    assign zero_now = bus.en && pend && (k == '0);

`ifdef NCO_SCHED_DITHER_EN
    logic [15:0]    lfsr;
    logic [PW+15:0] ext;

    always_comb begin
        ph_sel = zero_now ? '0 : phase[ch];
        ext    = {ph_sel, 16'h0}
               - (k[0] ? {2'b01, {(PW+14){1'b0}}} : '0)
               + ((PW+16)'(lfsr) << (PW - NBA));
        ang    = ext[PW+15 -: NBA];
    end

    always_ff @(posedge c) begin
        if (r)
            lfsr <= 16'hACE1;
        else if (bus.en)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
`else
    localparam logic [NBA-1:0] QTR = {2'b01, {(NBA-2){1'b0}}};

    // Subtracting 2^(PW-2) only touches the kept top bits, so do it after the cut.
    always_comb begin
        ph_sel = zero_now ? '0 : phase[ch];
        ang    = ph_sel[PW-1 -: NBA] - (k[0] ? QTR : '0);
    end
`endif

    always_comb begin
        a_n = ang[NBA-2] ? ~ang[NBA-3:0] : ang[NBA-3:0];
        s_n = ang[NBA-1] ^ ang[NBA-2];
    end

    always_ff @(posedge c) begin
        if (r) begin
            k       <= '0;
            pend    <= 1'b0;
            a_r     <= '0;
            s_r     <= 1'b0;
            issue_r <= 1'b0;
            frame_r <= 1'b0;
            iss_ch  <= '0;
            iss_sin <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                phase[i] <= '0;
                fw[i]    <= '0;
            end
        end else begin
            pend    <= bus.sync | (pend & ~zero_now);
            issue_r <= bus.en;
            frame_r <= bus.en && (k == '0);
            if (bus.en) begin
                a_r     <= a_n;
                s_r     <= s_n;
                iss_ch  <= ch;
                iss_sin <= k[0];
                k       <= k + KW'(1);
                if (zero_now) begin
                    for (int unsigned i = 0; i < NCH; i++)
                        phase[i] <= '0;
                end
                if (k[0])
                    phase[ch] <= ph_sel + fw[ch];
            end
            if (bus.fw_we)
                fw[bus.fw_ch] <= bus.fw_d;
        end
    end

    always_ff @(posedge c) begin
        if (r) begin
            for (int unsigned i = 0; i < LAT; i++)
                tag_line[i] <= '0;
        end else begin
            tag_line[0] <= {issue_r, iss_ch, iss_sin};
            for (int unsigned i = 1; i < LAT; i++)
                tag_line[i] <= tag_line[i-1];
        end
    end

    assign bus.a       = a_r;
    assign bus.s       = s_r;
    assign bus.issue   = issue_r;
    assign bus.frame   = frame_r;
    assign bus.o_valid = tag_line[LAT-1][CW+1];
    assign bus.o_ch    = tag_line[LAT-1][CW:1];
    assign bus.o_sin   = tag_line[LAT-1][0];
endmodule
